risc4_sequencer: RTL and testbench
==================================

RISC4_SEQUENCER -- requirements
Module: risc4_sequencer

Interface
REQ-001 Parameter PC_W SHALL be: PC_W, default 4, program-counter and instruction-address width.
REQ-002 Parameter RESET_PC SHALL be: RESET_PC, default 0, PC value loaded on reset.
REQ-003 Port SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port SHALL be: reset  input  1  synchronous, active-high reset.
REQ-005 Port SHALL be: start  input  1  leave IDLE and begin fetching at current PC.
REQ-006 Port SHALL be: imem_req  output  1  instruction fetch request.
REQ-007 Port SHALL be: imem_addr  output  PC_W  fetch address, equal to PC.
REQ-008 Port SHALL be: imem_valid  input  1  imem_data valid, completes fetch.
REQ-009 Port SHALL be: imem_data  input  8  instruction: [7:5] opcode, [3:2] rd, [1:0] rs, [3:0] branch target.
REQ-010 Port SHALL be: rf_raddr_a / rf_raddr_b  output  2 each  register-file read addresses (rd, rs).
REQ-011 Port SHALL be: alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-012 Port SHALL be: alu_en  output  1  ALU operand-capture strobe.
REQ-013 Port SHALL be: alu_zero  input  1  ALU result-is-zero, sampled in WB.
REQ-014 Port SHALL be: rf_we / rf_waddr  output  1 / 2  register write strobe and address (rd).
REQ-015 Port SHALL be: busy, halted, retire  output  1 each  not-IDLE/HALTED, in HALTED, one-cycle pulse per completed instruction.

Function
REQ-016 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MOV (rd<=rs, alu_op=OR with rf_raddr_a=rs), 101 BZ, 110 NOP, 111 HALT; bit 4 ignored.
REQ-017 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB, HALTED.
REQ-018 IDLE->FETCH SHALL occur on start=1; start in any other state SHALL be ignored.
REQ-019 In FETCH imem_req SHALL be 1 with imem_addr=PC, held stable until imem_valid=1; then IR<=imem_data, ->DECODE; imem_valid outside FETCH SHALL be ignored.
REQ-020 DECODE SHALL last one cycle: ALU ops/MOV ->EXEC; BZ ->EXEC; NOP ->FETCH with PC+1 and retire=1; HALT ->HALTED with retire=1, PC unchanged.
REQ-021 EXEC SHALL last one cycle with alu_en=1, alu_op, rf_raddr_a/b driven from IR; ALU ops ->WB.
REQ-022 WB SHALL last one cycle with rf_we=1, rf_waddr=rd; internal zero flag <= alu_zero; PC<=PC+1; retire=1; ->FETCH.
REQ-023 BZ in EXEC SHALL set PC<=IR[3:0] (zero-extended/truncated to PC_W) if zero flag=1 else PC+1, retire=1, ->FETCH; no rf_we, zero flag unchanged.
REQ-024 PC increment SHALL wrap modulo 2^PC_W (max -> 0) with no flag.
REQ-025 Minimum latency SHALL be 4 cycles per ALU instruction (FETCH with imem_valid already high, DECODE, EXEC, WB); 3 for BZ; 2 for NOP.
REQ-026 HALTED SHALL persist until reset; busy=0, halted=1, all strobes 0.
REQ-027 rf_raddr_a/b, alu_op SHALL hold last IR-derived values outside EXEC; strobes SHALL be 0 outside their state.

Reset
REQ-028 reset=1 at any clock edge, in any state including mid-FETCH, SHALL force IDLE, PC=RESET_PC, IR=0, zero flag=0, all outputs 0 except imem_addr=RESET_PC; no partial write shall occur.

Configuration
REQ-029 Macro RISC4_SEQ_BRANCH_EN SHALL select branching: defined -> BZ per REQ-023; undefined -> opcode 101 SHALL behave exactly as NOP and the zero flag register SHALL be omitted.

Structure
REQ-030 Package risc4_pkg SHALL hold the opcode enum, FSM state enum, ALU-op constants, instruction field positions.
REQ-031 Combinational sub-module risc4_decoder SHALL map IR to opcode class, alu_op, rd, rs, target.

Verification
REQ-032 Reset then start, imem_data=0x06 (ADD r1,r2), imem_valid high -> rf_we=1, rf_waddr=1, alu_op=00 on 4th cycle after start; retire pulse same cycle; imem_addr then 1.
REQ-033 imem_valid withheld 5 cycles in FETCH -> imem_req/imem_addr stable throughout, no state advance.
REQ-034 SUB with alu_zero=1 in WB then BZ 0x0A (0xAA) -> next imem_addr=0xA; with alu_zero=0 -> PC+1; macro undefined -> always PC+1.
REQ-035 PC=15, NOP -> next imem_addr=0; HALT (0xE0) -> halted=1, busy=0, start ignored, reset returns IDLE with PC=0.
REQ-036 reset asserted during EXEC -> next cycle IDLE, rf_we never asserted, all outputs 0.

Source files
------------

// File: rtl/risc4_pkg.sv
// Shared types and constants for the 4-bit-PC RISC sequencer: opcodes, FSM states,
// ALU op encodings, instruction field positions and decoded op classes.
package risc4_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_MOV  = 3'b100,
      OP_BZ   = 3'b101,
      OP_NOP  = 3'b110,
      OP_HALT = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_HALTED
   } state_e;

   typedef enum logic [1:0] {
      CLS_ALU,
      CLS_BRANCH,
      CLS_NOP,
      CLS_HALT
   } op_class_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   localparam int OPC_LSB = 5;
   localparam int RD_LSB  = 2;
   localparam int RS_LSB  = 0;
   localparam int TGT_LSB = 0;

endpackage

// File: rtl/risc4_decoder.sv
// Combinational instruction decoder. Opcode 101 decodes as a branch only when
// RISC4_SEQ_BRANCH_EN is defined; otherwise it is treated as a NOP.
module risc4_decoder
   import risc4_pkg::*;
(
   input  logic [7:0] ir,
   output op_class_e  op_class,
   output logic [1:0] alu_op,
   output logic [1:0] rd,
   output logic [1:0] rs,
   output logic [1:0] raddr_a,
   output logic [1:0] raddr_b,
   output logic [3:0] target
);

   opcode_e opcode;

   assign opcode  = opcode_e'(ir[OPC_LSB +: 3]);
   assign rd      = ir[RD_LSB +: 2];
   assign rs      = ir[RS_LSB +: 2];
   assign target  = ir[TGT_LSB +: 4];
   assign raddr_b = rs;

   // MOV is realised as rs OR rs, so port A is steered to rs as well.
   always_comb begin
      op_class = CLS_NOP;
      alu_op   = ALU_ADD;
      raddr_a  = rd;
      case (opcode)
         OP_ADD:  begin op_class = CLS_ALU; alu_op = ALU_ADD; end
         OP_SUB:  begin op_class = CLS_ALU; alu_op = ALU_SUB; end
         OP_AND:  begin op_class = CLS_ALU; alu_op = ALU_AND; end
         OP_OR:   begin op_class = CLS_ALU; alu_op = ALU_OR;  end
         OP_MOV:  begin op_class = CLS_ALU; alu_op = ALU_OR; raddr_a = rs; end
`ifdef RISC4_SEQ_BRANCH_EN
         OP_BZ:   op_class = CLS_BRANCH;
`else
         OP_BZ:   op_class = CLS_NOP;
`endif
         OP_NOP:  op_class = CLS_NOP;
         OP_HALT: op_class = CLS_HALT;
         default: op_class = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/risc4_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for a tiny 4-register RISC.
// Define RISC4_SEQ_BRANCH_EN to enable BZ and the zero-flag register.
module risc4_sequencer
   import risc4_pkg::*;
#(
   parameter int              PC_W     = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [7:0]      imem_data,
   output logic [1:0]      rf_raddr_a,
   output logic [1:0]      rf_raddr_b,
   output logic [1:0]      alu_op,
   output logic            alu_en,
   input  logic            alu_zero,
   output logic            rf_we,
   output logic [1:0]      rf_waddr,
   output logic            busy,
   output logic            halted,
   output logic            retire
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc;
   logic [7:0]      ir_q;
   op_class_e       op_class;
   logic [1:0]      rd, rs;
   logic [3:0]      target;

   risc4_decoder u_decoder (
      .ir       (ir_q),
      .op_class (op_class),
      .alu_op   (alu_op),
      .rd       (rd),
      .rs       (rs),
      .raddr_a  (rf_raddr_a),
      .raddr_b  (rf_raddr_b),
      .target   (target)
   );

   assign pc_inc    = pc_q + PC_W'(1);
   assign imem_addr = pc_q;
   assign rf_waddr  = rd;

`ifdef RISC4_SEQ_BRANCH_EN
   logic zero_q;

   always_ff @(posedge clk) begin
      if (reset)
         zero_q <= 1'b0;
      else if (state_q == ST_WB)
         zero_q <= alu_zero;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (state_q == ST_FETCH && imem_valid)
            ir_q <= imem_data;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH:  if (imem_valid) state_d = ST_DECODE;
         ST_DECODE: begin
            case (op_class)
               CLS_ALU, CLS_BRANCH: state_d = ST_EXEC;
               CLS_HALT:            state_d = ST_HALTED;
               default: begin
                  state_d = ST_FETCH;
                  pc_d    = pc_inc;
               end
            endcase
         end
         ST_EXEC: begin
            if (op_class == CLS_BRANCH) begin
               state_d = ST_FETCH;
`ifdef RISC4_SEQ_BRANCH_EN
               pc_d    = zero_q ? PC_W'(target) : pc_inc;
`else
               pc_d    = pc_inc;
`endif
            end else begin
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_req = (state_q == ST_FETCH);
      alu_en   = (state_q == ST_EXEC);
      rf_we    = (state_q == ST_WB);
      busy     = (state_q != ST_IDLE) && (state_q != ST_HALTED);
      halted   = (state_q == ST_HALTED);
      retire   = (state_q == ST_WB)
              || (state_q == ST_EXEC && op_class == CLS_BRANCH)
              || (state_q == ST_DECODE && (op_class == CLS_NOP || op_class == CLS_HALT));
   end

endmodule

// File: tb/tb_risc4_sequencer.sv
// Directed scoreboard bench for risc4_sequencer; tracks PC and zero flag in a small model.
module tb_risc4_sequencer;

`ifdef RISC4_SEQ_BRANCH_EN
   localparam bit BR = 1'b1;
`else
   localparam bit BR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, start, imem_valid, alu_zero;
   logic [7:0] imem_data;
   logic       imem_req, alu_en, rf_we, busy, halted, retire;
   logic [3:0] imem_addr;
   logic [1:0] rf_raddr_a, rf_raddr_b, alu_op, rf_waddr;

   int n_chk  = 0;
   int n_pass = 0;
   int wq[$];
   logic [3:0] mpc;
   logic       mzf;

   risc4_sequencer #(.PC_W(4), .RESET_PC(4'd0)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_data  (imem_data),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .alu_op     (alu_op),
      .alu_en     (alu_en),
      .alu_zero   (alu_zero),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .busy       (busy),
      .halted     (halted),
      .retire     (retire)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every register write must match the next expected destination in the scoreboard.
   always @(negedge clk) begin
      if (rf_we !== 1'b0) begin
         if (wq.size() == 0) begin
            chk("rf_we_unexpected", {31'd0, rf_we}, 32'd0);
         end else begin
            int e;
            e = wq.pop_front();
            chk("rf_waddr", {30'd0, rf_waddr}, e);
         end
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_busy"},     busy,       0);
      chk({tag, "_halted"},   halted,     0);
      chk({tag, "_req"},      imem_req,   0);
      chk({tag, "_addr"},     imem_addr,  0);
      chk({tag, "_alu_en"},   alu_en,     0);
      chk({tag, "_rf_we"},    rf_we,      0);
      chk({tag, "_retire"},   retire,     0);
      chk({tag, "_alu_op"},   alu_op,     0);
      chk({tag, "_raddr_a"},  rf_raddr_a, 0);
      chk({tag, "_raddr_b"},  rf_raddr_b, 0);
      chk({tag, "_waddr"},    rf_waddr,   0);
   endtask

   // Called with the DUT in FETCH; runs one instruction and checks latency and next PC.
   task automatic run(input logic [7:0] instr, input logic az, input string tag);
      logic [2:0] opc;
      logic       is_alu, is_bz;
      int         lat, cyc;
      logic [1:0] exp_op, exp_a;
      opc    = instr[7:5];
      is_alu = (opc <= 3'd4);
      is_bz  = (opc == 3'd5) && BR;
      lat    = is_alu ? 4 : (is_bz ? 3 : 2);
      exp_op = (opc < 3'd4) ? opc[1:0] : 2'b11;
      exp_a  = (opc == 3'd4) ? instr[1:0] : instr[3:2];
      if (is_alu) wq.push_back(int'(instr[3:2]));
      imem_data  = instr;
      imem_valid = 1'b1;
      alu_zero   = az;
      cyc = 0;
      while (retire !== 1'b1 && cyc < 8) begin
         step();
         cyc++;
         if (cyc == 2 && is_alu) begin
            chk({tag, "_alu_en"},  alu_en,     1);
            chk({tag, "_alu_op"},  alu_op,     exp_op);
            chk({tag, "_raddr_a"}, rf_raddr_a, exp_a);
            chk({tag, "_raddr_b"}, rf_raddr_b, instr[1:0]);
         end
      end
      chk({tag, "_latency"}, cyc, lat - 1);
      chk({tag, "_rf_we_at_retire"}, rf_we, is_alu);
      if (is_alu) begin
         mpc = mpc + 4'd1;
         mzf = az;
      end else if (is_bz && mzf) begin
         mpc = instr[3:0];
      end else begin
         mpc = mpc + 4'd1;
      end
      step();
      imem_valid = 1'b0;
      chk({tag, "_next_addr"}, imem_addr, mpc);
      chk({tag, "_next_req"},  imem_req,  1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; imem_valid = 1'b0; alu_zero = 1'b0; imem_data = 8'h00;
      mpc = 4'd0; mzf = 1'b0;
      step(); step();
      check_idle("reset");
      reset = 1'b0;
      step();
      chk("idle_no_start_busy", busy, 0);

      // Start with instruction memory stalled for five cycles.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_req",  imem_req,  1);
         chk("stall_addr", imem_addr, 0);
         chk("stall_busy", busy,      1);
         step();
      end
      chk("stall_still_fetch", imem_req, 1);

      run(8'h06, 1'b0, "add_r1_r2");
      run(8'h20, 1'b1, "sub_zero");
      run(8'hAA, 1'b0, "bz_taken");
      run(8'h21, 1'b0, "sub_nonzero");
      run(8'hAA, 1'b1, "bz_not_taken");
      run(8'h86, 1'b0, "mov_r1_r2");
      run(8'h4B, 1'b0, "and_r2_r3");
      run(8'h6F, 1'b0, "or_r3_r3");
      run(8'h16, 1'b0, "add_bit4_set");

      for (int i = 0; i < 16 && mpc != 4'd15; i++) run(8'hC0, 1'b0, "nop_walk");
      chk("pc_at_15", imem_addr, 15);
      run(8'hC0, 1'b0, "nop_wrap");

      // HALT: retires in DECODE then parks in HALTED.
      imem_data = 8'hE0; imem_valid = 1'b1;
      step();
      chk("halt_retire", retire, 1);
      step();
      imem_valid = 1'b0;
      chk("halt_halted", halted,    1);
      chk("halt_busy",   busy,      0);
      chk("halt_req",    imem_req,  0);
      chk("halt_retire_after", retire, 0);
      chk("halt_addr",   imem_addr, mpc);
      start = 1'b1;
      step(); step();
      start = 1'b0;
      chk("halt_start_ignored", halted, 1);
      chk("halt_start_busy",    busy,   0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle("halt_reset");
      mpc = 4'd0; mzf = 1'b0;

      // Reset while an ADD r3,r1 is in EXEC must not produce a write.
      start = 1'b1;
      step();
      start = 1'b0;
      imem_data = 8'h0D; imem_valid = 1'b1;
      step(); step();
      chk("midexec_alu_en", alu_en, 1);
      reset = 1'b1;
      step();
      check_idle("midexec_reset");
      step();
      reset = 1'b0; imem_valid = 1'b0;
      step(); step();
      chk("midexec_idle_busy", busy, 0);
      chk("scoreboard_empty", wq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
